// File: rtl/mips_bus_master_arb.sv
// mips_bus_master_arb
// Arbitrates N_CH requesters (default: ch0 = instruction fetch, ch1 = load/store)
// onto one Avalon-MM master port. Each accepted request is a byte, halfword or
// word access. Misaligned accesses are answered with an error and never reach
// the bus.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   req_*               per-channel request bundle; req_ready pulses on accept
//   rsp_valid/rdata/err per-channel one-cycle response with extended load data
//   busy                high whenever the master is not idle
//   address, read, write, waitrequest, writedata, byteenable, readdata
//                       Avalon-MM master signals
module mips_bus_master_arb #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        req_valid,
    input  logic [N_CH*ADDR_W-1:0] req_addr,
    input  logic [N_CH-1:0]        req_write,
    input  logic [N_CH*2-1:0]      req_size,
    input  logic [N_CH-1:0]        req_signed,
    input  logic [N_CH*32-1:0]     req_wdata,
    output logic [N_CH-1:0]        req_ready,
    output logic [N_CH-1:0]        rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [31:0]            address,
    output logic                   read,
    output logic                   write,
    input  logic                   waitrequest,
    output logic [31:0]            writedata,
    output logic [3:0]             byteenable,
    input  logic [31:0]            readdata
);

    localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   winner_q, winner_d;
    logic [IdxW-1:0]   last_grant_q, last_grant_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        alo_q, alo_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       address_q, address_d;
    logic [31:0]       writedata_q, writedata_d;
    logic [3:0]        byteenable_q, byteenable_d;
    logic              read_q, read_d;
    logic              write_q, write_d;

    logic              grant_found;
    logic [IdxW-1:0]   grant_idx;
    int unsigned       cand;
    int unsigned       gsel;
    logic [31:0]       sel_addr;
    logic              sel_write;
    logic [1:0]        sel_size;
    logic              sel_signed;
    logic [31:0]       sel_wdata;
    logic              misaligned;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wrep;
    logic [31:0]       shifted;
    logic [31:0]       load_ext;

    // Round-robin searches from last_grant+1 upward with wrap; fixed priority from 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ARB_MODE == 32'd1) begin
                cand = i;
            end else begin
                cand = (32'(last_grant_q) + 32'd1 + i) % N_CH;
            end
            if (!grant_found && req_valid[IdxW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'(cand);
            end
        end
    end

    // Winning channel's fields, plus lane steering for the store path.
    always_comb begin
        gsel       = 32'(grant_idx);
        sel_addr   = 32'(req_addr[gsel*ADDR_W +: ADDR_W]);
        sel_write  = req_write[grant_idx];
        sel_size   = req_size[gsel*2 +: 2];
        sel_signed = req_signed[grant_idx];
        sel_wdata  = req_wdata[gsel*32 +: 32];

        misaligned = ((sel_size == 2'b01) && sel_addr[0]) ||
                     (sel_size[1] && (sel_addr[1:0] != 2'b00));

        unique case (sel_size)
            2'b00: begin
                sel_be   = 4'b0001 << sel_addr[1:0];
                sel_wrep = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                sel_be   = sel_addr[1] ? 4'b1100 : 4'b0011;
                sel_wrep = {2{sel_wdata[15:0]}};
            end
            default: begin
                sel_be   = 4'b1111;
                sel_wrep = sel_wdata;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = readdata >> {alo_q, 3'b000};
        unique case (size_q)
            2'b00:   load_ext = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'h0, shifted[7:0]};
            2'b01:   load_ext = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        alo_d        = alo_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        read_d       = read_q;
        write_d      = write_q;
        req_ready    = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    // Masked in reset so no requester sees an accept that never happens.
                    if (reset) req_ready = N_CH'(1) << grant_idx;
                    winner_d     = grant_idx;
                    last_grant_d = grant_idx;
                    wr_d         = sel_write;
                    size_d       = sel_size;
                    signed_d     = sel_signed;
                    alo_d        = sel_addr[1:0];
                    err_d        = misaligned;
                    rdata_d      = '0;
                    if (misaligned) begin
                        state_d = StResp;
                    end else begin
                        state_d      = StBus;
                        address_d    = {sel_addr[31:2], 2'b00};
                        writedata_d  = sel_wrep;
                        byteenable_d = sel_be;
                        read_d       = !sel_write;
                        write_d      = sel_write;
                    end
                end
            end
            StBus: begin
                if (!waitrequest) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    byteenable_d = 4'b0000;
                    if (!wr_q) rdata_d = load_ext;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            winner_q     <= '0;
            last_grant_q <= IdxW'(N_CH - 1);
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            alo_q        <= 2'b00;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            alo_q        <= alo_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == StResp) rsp_valid = N_CH'(1) << winner_q;
    end

    assign rsp_err    = (state_q == StResp) && err_q;
    assign rsp_rdata  = rdata_q;
    assign busy       = (state_q != StIdle);
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign read       = read_q;
    assign write      = write_q;

endmodule

// File: tb/tb_mips_bus_master_arb.sv
// Scoreboard bench for mips_bus_master_arb: stimulus pushes expected grants and
// responses into queues; a negedge monitor pops and compares them, and checks
// Avalon fields on every strobe cycle. A second instance covers fixed priority.
module tb_mips_bus_master_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req_valid, req_valid_fp;
    logic [63:0] req_addr;
    logic [1:0]  req_write;
    logic [3:0]  req_size;
    logic [1:0]  req_signed;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err, busy;
    logic [31:0] address;
    logic        read, write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    logic [1:0]  req_ready_fp, rsp_valid_fp;
    logic [31:0] rsp_rdata_fp, address_fp, writedata_fp;
    logic        rsp_err_fp, busy_fp, read_fp, write_fp;
    logic [3:0]  byteenable_fp;

    mips_bus_master_arb #(.N_CH(2), .ARB_MODE(0), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .address(address),
        .read(read), .write(write), .waitrequest(waitrequest), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata)
    );

    mips_bus_master_arb #(.N_CH(2), .ARB_MODE(1), .ADDR_W(32)) dut_fp (
        .clk(clk), .reset(reset), .req_valid(req_valid_fp), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .req_ready(req_ready_fp), .rsp_valid(rsp_valid_fp),
        .rsp_rdata(rsp_rdata_fp), .rsp_err(rsp_err_fp), .busy(busy_fp),
        .address(address_fp), .read(read_fp), .write(write_fp), .waitrequest(1'b0),
        .writedata(writedata_fp), .byteenable(byteenable_fp), .readdata(readdata)
    );

    typedef struct {
        int          ch;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          grant_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          wcnt = 0;
    int          strobe_cnt = 0;
    int          fp_grants = 0;
    logic        bus_chk = 1'b0;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic        exp_wr;
    rsp_t        mon_e;
    int          mon_g;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Avalon slave: stall each transfer for wcnt cycles.
    initial begin
        waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if ((read || write) && wcnt > 0) begin
                waitrequest = 1'b1;
                wcnt--;
            end else begin
                waitrequest = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && (|req_ready) === 1'b1) begin
            if (grant_q.size() == 0) begin
                chk("unexpected_grant", 32'(req_ready), 32'h0);
            end else begin
                mon_g = grant_q.pop_front();
                chk("grant", 32'(req_ready), 32'(1) << mon_g);
                acc_cyc = cyc;
            end
        end
        if ((|rsp_valid) === 1'b1) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                mon_e = rsp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1) << mon_e.ch);
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                chk("rsp_latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
            end
        end
        if (read === 1'b1 || write === 1'b1) begin
            strobe_cnt++;
            if (bus_chk) begin
                chk("bus_address", address, exp_addr);
                chk("bus_byteenable", 32'(byteenable), 32'(exp_be));
                chk("bus_write", 32'(write), 32'(exp_wr));
                chk("bus_read", 32'(read), 32'(!exp_wr));
                if (exp_wr) chk("bus_writedata", writedata, exp_wd);
            end
        end
        if ((|req_ready_fp) === 1'b1) begin
            fp_grants++;
            chk("fp_grant", 32'(req_ready_fp), 32'h1);
        end
    end

    task automatic set_req(input int ch, input logic [31:0] addr, input logic wr,
                           input logic [1:0] sz, input logic sgn, input logic [31:0] wd);
        req_addr[ch*32 +: 32] = addr;
        req_write[ch]         = wr;
        req_size[ch*2 +: 2]   = sz;
        req_signed[ch]        = sgn;
        req_wdata[ch*32 +: 32] = wd;
    endtask

    task automatic expect_txn(input int ch, input logic [31:0] rd, input logic err,
                              input int lat, input logic has_rsp);
        rsp_t e;
        grant_q.push_back(ch);
        if (has_rsp) begin
            e.ch = ch; e.err = err; e.rdata = rd; e.lat = lat;
            rsp_q.push_back(e);
        end
    endtask

    // Wait for accept on ch (bounded), then drop its valid.
    task automatic handshake(input int ch);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready[ch] !== 1'b1 && n < 50);
        if (n >= 50) chk("accept_timeout", 32'(req_ready), 32'(1) << ch);
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rsp_q.size() != 0 || grant_q.size() != 0 || busy !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(rsp_q.size()), 32'h0);
    endtask

    task automatic txn(input int ch, input logic [31:0] addr, input logic wr,
                       input logic [1:0] sz, input logic sgn, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [31:0] exp_rd, input logic err,
                       input int wt, input logic [3:0] be, input logic [31:0] ewd,
                       input int strobes);
        @(posedge clk); #1;
        exp_addr = {addr[31:2], 2'b00};
        exp_be = be; exp_wd = ewd; exp_wr = wr;
        bus_chk = 1'b1;
        strobe_cnt = 0;
        wcnt = wt;
        readdata = rd;
        set_req(ch, addr, wr, sz, sgn, wd);
        expect_txn(ch, exp_rd, err, err ? 1 : 2 + wt, 1'b1);
        req_valid[ch] = 1'b1;
        handshake(ch);
        wait_drain();
        chk("strobe_cycles", 32'(strobe_cnt), 32'(strobes));
        chk("idle_byteenable", 32'(byteenable), 32'h0);
        chk("idle_strobes", 32'({read, write}), 32'h0);
        bus_chk = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0;
        req_valid = '0; req_valid_fp = '0;
        req_addr = '0; req_write = '0; req_size = '0; req_signed = '0; req_wdata = '0;
        readdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobes", 32'({read, write}), 32'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_byteenable", 32'(byteenable), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);

        //   ch addr           wr  sz     sgn wdata         readdata      exp_rdata     err wt be      exp_wd        strobes
        txn(1, 32'h0000_1004, 0, 2'b10, 0, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 3, 4'b1111, 32'h0,        4);
        txn(0, 32'h0000_1003, 0, 2'b00, 1, 32'h0,        32'h8000_0000, 32'hFFFF_FF80, 0, 0, 4'b1000, 32'h0,        1);
        txn(0, 32'h0000_1003, 0, 2'b00, 0, 32'h0,        32'h8000_0000, 32'h0000_0080, 0, 1, 4'b1000, 32'h0,        2);
        txn(1, 32'h0000_2002, 1, 2'b01, 0, 32'h0000_ABCD, 32'h1111_1111, 32'h0,        0, 0, 4'b1100, 32'hABCD_ABCD, 1);
        txn(0, 32'h0000_0006, 0, 2'b10, 0, 32'h0,        32'h1111_1111, 32'h0,        1, 0, 4'b0000, 32'h0,        0);
        txn(1, 32'h0000_0002, 0, 2'b01, 1, 32'h0,        32'h8001_0000, 32'hFFFF_8001, 0, 2, 4'b1100, 32'h0,        3);
        txn(0, 32'h0000_0001, 1, 2'b00, 0, 32'h0000_005A, 32'h0,        32'h0,        0, 0, 4'b0010, 32'h5A5A_5A5A, 1);
        txn(1, 32'h0000_0003, 0, 2'b11, 1, 32'h0,        32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        0);
        txn(0, 32'h0000_0101, 0, 2'b01, 0, 32'h0,        32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        0);

        // Reset in the second BUS cycle abandons the transfer; last grant was 0.
        @(posedge clk); #1;
        wcnt = 5;
        set_req(0, 32'h0000_0040, 0, 2'b10, 0, 32'h0);
        expect_txn(0, 32'h0, 0, 0, 1'b0);
        req_valid[0] = 1'b1;
        handshake(0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        wcnt = 0;
        @(negedge clk);
        chk("rst_bus_read", 32'(read), 32'h0);
        chk("rst_bus_busy", 32'(busy), 32'h0);
        chk("rst_bus_rsp_valid", 32'(rsp_valid), 32'h0);

        // After reset both request; channel 0 must win first.
        readdata = 32'hCAFE_F00D;
        set_req(0, 32'h0000_0100, 0, 2'b10, 0, 32'h0);
        set_req(1, 32'h0000_0204, 0, 2'b10, 0, 32'h0);
        expect_txn(0, 32'hCAFE_F00D, 0, 2, 1'b1);
        expect_txn(1, 32'hCAFE_F00D, 0, 2, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        handshake(0);
        handshake(1);
        wait_drain();

        // Continuous contention, round-robin: 0, 1, 0, 1.
        readdata = 32'h1234_5678;
        for (int k = 0; k < 4; k++) expect_txn(k % 2, 32'h1234_5678, 0, 2, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        n = 0;
        while (grant_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("rr_timeout", 32'(grant_q.size()), 32'h0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_drain();

        // Fixed priority instance: channel 0 every time.
        fp_grants = 0;
        @(posedge clk); #1;
        req_valid_fp = 2'b11;
        n = 0;
        while (fp_grants < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid_fp = 2'b00;
        n = 0;
        while (busy_fp !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("fp_grant_count", 32'(fp_grants), 32'd4);

        repeat (3) @(negedge clk);
        chk("final_rsp_queue", 32'(rsp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
